// File: rtl/gpio_pad_sampler.sv
// gpio_pad_sampler: synchronises pad inputs, optionally debounces them, and raises sticky per-pin interrupt status
module gpio_pad_sampler #(
  parameter int NUM_GPIO = 64,
  parameter int NUM_PADS = 62,
  parameter int DEB_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_GPIO-1:0]   pad_in_i,
  input  logic [NUM_GPIO-1:0]   gpio_dir_i,
  input  logic [NUM_GPIO-1:0]   deb_en_i,
  input  logic [DEB_W-1:0]      deb_thresh_i,
  input  logic [NUM_GPIO-1:0]   irq_en_i,
  input  logic [2*NUM_GPIO-1:0] irq_type_i,
  input  logic [NUM_GPIO-1:0]   irq_clr_i,
  output logic [NUM_GPIO-1:0]   gpio_in_o,
  output logic [NUM_GPIO-1:0]   irq_status_o,
  output logic                  irq_o
);
  logic [NUM_PADS-1:0] s1_q, s2_q, filt_q, filt_d, status_q, status_d, evt;
  logic [DEB_W-1:0] cnt_q [NUM_PADS];
  logic [DEB_W-1:0] cnt_d [NUM_PADS];
  logic [1:0] typ;
  always_comb begin
    typ = 2'b00;
    for (int k = 0; k < NUM_PADS; k++) begin
      filt_d[k] = (!deb_en_i[k] || (s2_q[k] != filt_q[k] && cnt_q[k] >= deb_thresh_i)) ? s2_q[k] : filt_q[k];
      cnt_d[k] = (deb_en_i[k] && s2_q[k] != filt_q[k] && cnt_q[k] < deb_thresh_i) ? cnt_q[k] + 1'b1 : '0;
      typ = irq_type_i[2*k +: 2];
      evt[k] = irq_en_i[k] & ~gpio_dir_i[k] &
               (typ == 2'b00 ? filt_d[k] & ~filt_q[k] :
                typ == 2'b01 ? ~filt_d[k] & filt_q[k] :
                typ == 2'b10 ? filt_d[k] ^ filt_q[k] : filt_d[k]);
      status_d[k] = evt[k] | (status_q[k] & ~irq_clr_i[k]);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
      filt_q <= '0;
      status_q <= '0;
      for (int k = 0; k < NUM_PADS; k++) cnt_q[k] <= '0;
    end else begin
      s1_q <= pad_in_i[NUM_PADS-1:0];
      s2_q <= s1_q;
      filt_q <= filt_d;
      status_q <= status_d;
      cnt_q <= cnt_d;
    end
  end
  assign gpio_in_o = NUM_GPIO'(filt_q);
  assign irq_status_o = NUM_GPIO'(status_q);
  assign irq_o = |status_q;
  generate
    if (NUM_PADS < NUM_GPIO) begin : g_tie
      logic unused_hi;
      assign unused_hi = ^{pad_in_i[NUM_GPIO-1:NUM_PADS], gpio_dir_i[NUM_GPIO-1:NUM_PADS],
                           deb_en_i[NUM_GPIO-1:NUM_PADS], irq_en_i[NUM_GPIO-1:NUM_PADS],
                           irq_type_i[2*NUM_GPIO-1:2*NUM_PADS], irq_clr_i[NUM_GPIO-1:NUM_PADS]};
    end
  endgenerate
endmodule

// File: tb/tb_gpio_pad_sampler.sv
// tb_gpio_pad_sampler: directed stimulus with a cycle-stamped expectation queue drained by a monitor
module tb_gpio_pad_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] pad = '0, dir = '0, deb_en = '0, irq_en = '0, clr = '0;
  logic [127:0] irq_type = '0;
  logic [7:0] th = '0;
  logic [63:0] gpio_in, irq_st;
  logic irq;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    string nm;
    int due;
    logic [63:0] mask;
    logic [63:0] ein;
    logic [63:0] est;
    logic eirq;
  } exp_t;
  exp_t q[$];
  gpio_pad_sampler #(.NUM_GPIO(64), .NUM_PADS(62), .DEB_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .pad_in_i(pad), .gpio_dir_i(dir), .deb_en_i(deb_en),
    .deb_thresh_i(th), .irq_en_i(irq_en), .irq_type_i(irq_type), .irq_clr_i(clr),
    .gpio_in_o(gpio_in), .irq_status_o(irq_st), .irq_o(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input string nm, input int dly, input int pin, input logic i, input logic s, input logic ir);
    exp_t e;
    e.nm = nm;
    e.due = cyc + dly;
    e.mask = 64'd1 << pin;
    e.ein = {64{i}};
    e.est = {64{s}};
    e.eirq = ir;
    q.push_back(e);
  endtask
  task automatic push_all(input string nm, input int dly, input logic [63:0] i, input logic [63:0] s, input logic ir);
    exp_t e;
    e.nm = nm;
    e.due = cyc + dly;
    e.mask = '1;
    e.ein = i;
    e.est = s;
    e.eirq = ir;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due <= cyc) begin
        n_chk++;
        if (q[i].due < cyc || ((gpio_in ^ q[i].ein) & q[i].mask) !== '0 ||
            ((irq_st ^ q[i].est) & q[i].mask) !== '0 || irq !== q[i].eirq) begin
          n_fail++;
          $display("FAIL %s cyc=%0d due=%0d: got gpio_in=%h status=%h irq=%b, expected gpio_in=%h status=%h irq=%b (mask %h)",
                   q[i].nm, cyc, q[i].due, gpio_in & q[i].mask, irq_st & q[i].mask, irq,
                   q[i].ein & q[i].mask, q[i].est & q[i].mask, q[i].eirq, q[i].mask);
        end
        q.delete(i);
      end
    end
  end
  initial begin
    tick(4);
    rst = 1'b0;
    n_chk++;
    if (gpio_in !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_direct_gpio_in: got %h expected 0", gpio_in);
    end
    n_chk++;
    if (irq_st !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_direct_status: got %h expected 0", irq_st);
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_direct_irq: got %b expected 0", irq);
    end
    push_all("reset_state", 0, '0, '0, 1'b0);
    pad[63:62] = 2'b11;
    push("unbonded62", 3, 62, 1'b0, 1'b0, 1'b0);
    push("unbonded63", 4, 63, 1'b0, 1'b0, 1'b0);
    push_all("unbonded_all", 6, '0, '0, 1'b0);
    tick(8);
    irq_en[5] = 1'b1;
    irq_type[11:10] = 2'b00;
    pad[5] = 1'b1;
    push("p5_before", 2, 5, 1'b0, 1'b0, 1'b0);
    push("p5_rise", 3, 5, 1'b1, 1'b1, 1'b1);
    tick(3);
    clr[5] = 1'b1;
    push("p5_clear", 1, 5, 1'b1, 1'b0, 1'b0);
    tick(1);
    clr[5] = 1'b0;
    pad[5] = 1'b0;
    push("p5_fall_no_irq", 3, 5, 1'b0, 1'b0, 1'b0);
    tick(5);
    irq_en[5] = 1'b0;
    deb_en[10] = 1'b1;
    th = 8'd4;
    irq_en[10] = 1'b1;
    irq_type[21:20] = 2'b01;
    pad[10] = 1'b1;
    push("p10_glitch_a", 6, 10, 1'b0, 1'b0, 1'b0);
    push("p10_glitch_b", 9, 10, 1'b0, 1'b0, 1'b0);
    tick(4);
    pad[10] = 1'b0;
    tick(8);
    pad[10] = 1'b1;
    push("p10_deb_before", 6, 10, 1'b0, 1'b0, 1'b0);
    push("p10_deb_rise", 7, 10, 1'b1, 1'b0, 1'b0);
    tick(5);
    pad[10] = 1'b0;
    push("p10_fall_before", 6, 10, 1'b1, 1'b0, 1'b0);
    push("p10_fall_irq", 7, 10, 1'b0, 1'b1, 1'b1);
    tick(9);
    clr[10] = 1'b1;
    push("p10_clear", 1, 10, 1'b0, 1'b0, 1'b0);
    tick(1);
    clr[10] = 1'b0;
    irq_en[10] = 1'b0;
    deb_en[10] = 1'b0;
    tick(2);
    irq_en[20] = 1'b1;
    irq_type[41:40] = 2'b11;
    pad[20] = 1'b1;
    push("p20_level", 3, 20, 1'b1, 1'b1, 1'b1);
    tick(5);
    clr[20] = 1'b1;
    push("p20_set_wins", 1, 20, 1'b1, 1'b1, 1'b1);
    tick(1);
    clr[20] = 1'b0;
    pad[20] = 1'b0;
    push("p20_low_still_set", 3, 20, 1'b0, 1'b1, 1'b1);
    tick(4);
    clr[20] = 1'b1;
    push("p20_cleared", 1, 20, 1'b0, 1'b0, 1'b0);
    tick(1);
    clr[20] = 1'b0;
    push("p20_stays_clear", 3, 20, 1'b0, 1'b0, 1'b0);
    tick(4);
    irq_en[20] = 1'b0;
    dir[30] = 1'b1;
    irq_en[30] = 1'b1;
    irq_type[61:60] = 2'b10;
    pad[30] = 1'b1;
    push("p30_out_rise", 3, 30, 1'b1, 1'b0, 1'b0);
    tick(4);
    pad[30] = 1'b0;
    push("p30_out_fall", 3, 30, 1'b0, 1'b0, 1'b0);
    tick(4);
    dir[30] = 1'b0;
    pad[30] = 1'b1;
    push("p30_in_before", 2, 30, 1'b0, 1'b0, 1'b0);
    push("p30_in_rise", 3, 30, 1'b1, 1'b1, 1'b1);
    tick(4);
    irq_en[30] = 1'b0;
    push("p30_en_off_keeps", 2, 30, 1'b1, 1'b1, 1'b1);
    tick(3);
    deb_en[40] = 1'b1;
    th = 8'd200;
    pad[40] = 1'b1;
    push("p40_counting", 50, 40, 1'b0, 1'b0, 1'b1);
    tick(102);
    rst = 1'b1;
    push_all("mid_reset", 1, '0, '0, 1'b0);
    tick(1);
    rst = 1'b0;
    n_chk++;
    if (gpio_in !== 64'd0 || irq_st !== 64'd0) begin
      n_fail++;
      $display("FAIL mid_reset_direct: got gpio_in=%h status=%h expected 0", gpio_in, irq_st);
    end
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_direct_irq: got %b expected 0", irq);
    end
    push("p40_post_before", 202, 40, 1'b0, 1'b0, 1'b0);
    push("p40_post_rise", 203, 40, 1'b1, 1'b0, 1'b0);
    push("p30_post_reset", 3, 30, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && q.size() > 0; i++) tick(1);
    while (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: check due at cyc %0d never evaluated (now %0d)", q[0].nm, q[0].due, cyc);
      void'(q.pop_front());
    end
    if (n_fail == 0) $display("PASS");
    else $display("FAILED");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
